// File: rtl/simon_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : simon_sequencer                                               |
// | Purpose  : Simon Says game controller. Each round appends one random     |
// |            colour to the sequence, plays the sequence back on the LEDs,  |
// |            then checks the player's presses against it.                  |
// | Ports    : clk, reset_n (async, active-low), tick (timing enable),       |
// |            start (level), rnd[1:0] (LFSR colour), button[3:0] (player);  |
// |            colour[3:0] (LEDs), score[SW-1:0], busy, game_over, win.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module simon_sequencer #(
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 5_000_000,
  parameter int OFF_TICKS     = 2_500_000,
  parameter int TIMEOUT_TICKS = 30_000_000,
  localparam int SW           = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          start,
  input  logic [1:0]    rnd,
  input  logic [3:0]    button,
  output logic [3:0]    colour,
  output logic [SW-1:0] score,
  output logic          busy,
  output logic          game_over,
  output logic          win
);

  localparam int c_IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int c_TMR_MAX = (ON_TICKS > OFF_TICKS)
                             ? ((ON_TICKS  > TIMEOUT_TICKS) ? ON_TICKS  : TIMEOUT_TICKS)
                             : ((OFF_TICKS > TIMEOUT_TICKS) ? OFF_TICKS : TIMEOUT_TICKS);
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_RELEASE  = 3'd5,
    S_LOSE     = 3'd6,
    S_WIN      = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_TMR_W-1:0]   w_tmr_inc;
  logic [SW-1:0]        r_len;
  logic [SW-1:0]        w_len_next;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_IDX_W-1:0]   w_idx_next;
  logic [SW-1:0]        w_score_next;
  logic [3:0]           r_btn_prev;
  logic [1:0]           r_mem [MAX_LEN];
  logic                 w_mem_we;
  logic                 w_press;
  logic                 w_last;
  logic                 w_timed;
  logic [1:0]           w_show_val;
  logic [3:0]           w_colour_next;
  logic                 w_busy_next;
  logic                 w_over_next;
  logic                 w_win_next;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  assign w_tmr_inc = r_timer + c_TMR_W'(1);
  assign w_press   = (button != 4'b0000) && (r_btn_prev == 4'b0000);
  assign w_last    = (SW'(r_idx) == (r_len - SW'(1)));
  assign w_timed   = (r_state == S_SHOW_ON) || (r_state == S_SHOW_OFF) ||
                     (r_state == S_WAIT_IN) || (r_state == S_RELEASE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, datapath updates and next-cycle output values
  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_idx_next   = r_idx;
    w_score_next = score;
    w_mem_we     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_ADD;
          w_len_next   = '0;
          w_score_next = '0;
        end
      end
      S_ADD: begin
        w_mem_we     = 1'b1;
        w_len_next   = r_len + SW'(1);
        w_idx_next   = '0;
        w_state_next = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tick && (w_tmr_inc == c_TMR_W'(ON_TICKS))) begin
          w_state_next = S_SHOW_OFF;
        end
      end
      S_SHOW_OFF: begin
        if (tick && (w_tmr_inc == c_TMR_W'(OFF_TICKS))) begin
          if (w_last) begin
            w_idx_next   = '0;
            w_state_next = S_WAIT_IN;
          end else begin
            w_idx_next   = r_idx + c_IDX_W'(1);
            w_state_next = S_SHOW_ON;
          end
        end
      end
      S_WAIT_IN: begin
        // A press takes priority over a timeout landing in the same cycle
        if (w_press) begin
          w_state_next = (button == onehot(r_mem[r_idx])) ? S_RELEASE : S_LOSE;
        end else if (tick && (w_tmr_inc == c_TMR_W'(TIMEOUT_TICKS))) begin
          w_state_next = S_LOSE;
        end
      end
      S_RELEASE: begin
        if (button == 4'b0000) begin
          if (w_last) begin
            w_score_next = r_len;
            w_state_next = (r_len == SW'(MAX_LEN)) ? S_WIN : S_ADD;
          end else begin
            w_idx_next   = r_idx + c_IDX_W'(1);
            w_state_next = S_WAIT_IN;
          end
        end else if (tick && (w_tmr_inc == c_TMR_W'(TIMEOUT_TICKS))) begin
          w_state_next = S_LOSE;
        end
      end
      S_LOSE, S_WIN: begin
        if (!start) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // The first playback colour of round one is being written this very
    // cycle, so forward it instead of reading the not-yet-written entry.
    if ((r_state == S_ADD) && (r_len == '0)) begin
      w_show_val = rnd;
    end else begin
      w_show_val = r_mem[w_idx_next];
    end

    // Outputs are registered from the upcoming state so flags line up with it
    w_colour_next = 4'b0000;
    case (w_state_next)
      S_IDLE, S_WAIT_IN, S_RELEASE: w_colour_next = button;
      S_SHOW_ON:                    w_colour_next = onehot(w_show_val);
      S_LOSE:                       w_colour_next = 4'b1111;
      default:                      w_colour_next = 4'b0000;
    endcase
    w_busy_next = (w_state_next == S_ADD)     || (w_state_next == S_SHOW_ON) ||
                  (w_state_next == S_SHOW_OFF) || (w_state_next == S_WAIT_IN) ||
                  (w_state_next == S_RELEASE);
    w_over_next = (w_state_next == S_LOSE);
    w_win_next  = (w_state_next == S_WIN);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer    <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_btn_prev <= '0;
      colour     <= '0;
      score      <= '0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      r_btn_prev <= button;
      r_len      <= w_len_next;
      r_idx      <= w_idx_next;
      score      <= w_score_next;
      colour     <= w_colour_next;
      busy       <= w_busy_next;
      game_over  <= w_over_next;
      win        <= w_win_next;
      if (w_state_next != r_state) begin
        r_timer <= '0;
      end else if (tick && w_timed) begin
        r_timer <= w_tmr_inc;
      end
    end
  end

  // Sequence storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[c_IDX_W'(r_len)] <= rnd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_simon_sequencer                                            |
// | Purpose  : Self-checking bench for simon_sequencer. A game-level model   |
// |            (sequence queue, countdown of remaining ticks) predicts every |
// |            output each cycle; literal expectations pin key moments.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_simon_sequencer;

  localparam int MAX_LEN       = 3;
  localparam int ON_TICKS      = 2;
  localparam int OFF_TICKS     = 1;
  localparam int TIMEOUT_TICKS = 8;
  localparam int SW            = $clog2(MAX_LEN + 1);

  // Game phases of the model
  localparam int P_IDLE = 0, P_ADD = 1, P_ON = 2, P_OFF = 3;
  localparam int P_WAIT = 4, P_REL = 5, P_LOSE = 6, P_WIN = 7;

  // Literal-check field selectors
  localparam int F_COL = 0, F_SC = 1, F_BUSY = 2, F_GO = 3, F_WIN = 4, F_RAW = 5;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick    = 1'b0;
  logic          start   = 1'b0;
  logic [1:0]    rnd     = 2'd0;
  logic [3:0]    button  = 4'd0;
  logic [3:0]    colour;
  logic [SW-1:0] score;
  logic          busy;
  logic          game_over;
  logic          win;

  always #5 clk = ~clk;

  simon_sequencer #(
    .MAX_LEN       (MAX_LEN),
    .ON_TICKS      (ON_TICKS),
    .OFF_TICKS     (OFF_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .start     (start),
    .rnd       (rnd),
    .button    (button),
    .colour    (colour),
    .score     (score),
    .busy      (busy),
    .game_over (game_over),
    .win       (win)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [3:0]    exp_colour = '0;
  logic [SW-1:0] exp_score  = '0;
  logic          exp_busy   = 1'b0;
  logic          exp_go     = 1'b0;
  logic          exp_win    = 1'b0;

  string lit_name_q[$];
  int    lit_field_q[$];
  int    lit_val_q[$];
  int    lit_act_q[$];

  // ---------------- game model ----------------
  int         m_ph;
  int         m_pos;
  int         m_left;
  int         m_score;
  int         m_seq[$];
  logic [3:0] m_prev;
  logic [3:0] m_colour;
  logic       m_busy, m_go, m_win;

  function automatic logic [3:0] oh(input int c);
    logic [3:0] v;
    v    = 4'b0000;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic int dur(input int p);
    if (p == P_ON)                  return ON_TICKS;
    if (p == P_OFF)                 return OFF_TICKS;
    if (p == P_WAIT || p == P_REL)  return TIMEOUT_TICKS;
    return 0;
  endfunction

  function automatic void model_reset();
    m_ph = P_IDLE; m_pos = 0; m_left = 0; m_score = 0; m_prev = 4'b0000;
    m_seq.delete();
  endfunction

  // Advance the model by one clock with the given inputs; m_* outputs are the
  // values the DUT must show after that clock edge.
  function automatic void model_step(input logic s, input logic [1:0] r,
                                     input logic [3:0] b, input logic t);
    int np;
    bit press, expire;
    np     = m_ph;
    press  = (b != 4'b0000) && (m_prev == 4'b0000);
    expire = t && (m_left == 1);
    case (m_ph)
      P_IDLE: if (s) begin m_seq.delete(); m_score = 0; np = P_ADD; end
      P_ADD:  begin m_seq.push_back(int'(r)); m_pos = 0; np = P_ON; end
      P_ON:   if (expire) np = P_OFF;
      P_OFF:  if (expire) begin
                if (m_pos == m_seq.size() - 1) begin m_pos = 0; np = P_WAIT; end
                else begin m_pos++; np = P_ON; end
              end
      P_WAIT: if (press) np = (b == oh(m_seq[m_pos])) ? P_REL : P_LOSE;
              else if (expire) np = P_LOSE;
      P_REL:  if (b == 4'b0000) begin
                if (m_pos == m_seq.size() - 1) begin
                  m_score = m_seq.size();
                  np = (m_seq.size() == MAX_LEN) ? P_WIN : P_ADD;
                end else begin
                  m_pos++; np = P_WAIT;
                end
              end else if (expire) np = P_LOSE;
      default: if (!s) np = P_IDLE;
    endcase
    if (np != m_ph) m_left = dur(np);
    else if (t && m_left > 0) m_left--;
    m_ph   = np;
    m_prev = b;
    case (m_ph)
      P_IDLE, P_WAIT, P_REL: m_colour = b;
      P_ON:                  m_colour = oh(m_seq[m_pos]);
      P_LOSE:                m_colour = 4'b1111;
      default:               m_colour = 4'b0000;
    endcase
    m_busy = (m_ph >= P_ADD) && (m_ph <= P_REL);
    m_go   = (m_ph == P_LOSE);
    m_win  = (m_ph == P_WIN);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    string       n;
    int          f;
    int          v;
    logic [31:0] a;
    if (chk_en) begin
      checks++;
      if (colour !== exp_colour || score !== exp_score || busy !== exp_busy ||
          game_over !== exp_go || win !== exp_win) begin
        errors++;
        $display("FAIL model t=%0t actual col=%b score=%0d busy=%b go=%b win=%b required col=%b score=%0d busy=%b go=%b win=%b",
                 $time, colour, score, busy, game_over, win,
                 exp_colour, exp_score, exp_busy, exp_go, exp_win);
      end
    end
    while (lit_name_q.size() > 0) begin
      n = lit_name_q.pop_front();
      f = lit_field_q.pop_front();
      v = lit_val_q.pop_front();
      a = 32'(lit_act_q.pop_front());
      case (f)
        F_COL:   a = 32'(colour);
        F_SC:    a = 32'(score);
        F_BUSY:  a = 32'(busy);
        F_GO:    a = 32'(game_over);
        F_WIN:   a = 32'(win);
        default: ;
      endcase
      checks++;
      if (a !== 32'(v)) begin
        errors++;
        $display("FAIL %s actual=%0d required=%0d", n, a, v);
      end
    end
  end

  task automatic lit(input string n, input int f, input int v);
    lit_name_q.push_back(n); lit_field_q.push_back(f);
    lit_val_q.push_back(v);  lit_act_q.push_back(0);
  endtask

  task automatic lit_raw(input string n, input int act, input int req);
    lit_name_q.push_back(n); lit_field_q.push_back(F_RAW);
    lit_val_q.push_back(req); lit_act_q.push_back(act);
  endtask

  // One clock: apply inputs, step model, then publish the model's outputs
  task automatic dc(input logic s, input logic [1:0] r, input logic [3:0] b, input logic t);
    start = s; rnd = r; button = b; tick = t;
    model_step(s, r, b, t);
    @(posedge clk);
    #1;
    exp_colour = m_colour;
    exp_score  = SW'(m_score);
    exp_busy   = m_busy;
    exp_go     = m_go;
    exp_win    = m_win;
  endtask

  task automatic run_until(input int ph, input int lim);
    int n;
    n = 0;
    while (m_ph != ph && n < lim) begin
      dc(1'b1, 2'($urandom), 4'b0000, 1'b1);
      n++;
    end
    lit_raw("phase_reached", m_ph, ph);
  endtask

  task automatic play_round();
    run_until(P_WAIT, 40);
    for (int i = 0; i < m_seq.size(); i++) begin
      dc(1'b1, 2'd0, oh(m_seq[i]), 1'b1);
      dc(1'b1, 2'd0, 4'b0000, 1'b1);
    end
  endtask

  task automatic pulse_reset(input bit with_lits);
    reset_n = 1'b0;
    model_reset();
    exp_colour = '0; exp_score = '0; exp_busy = 1'b0; exp_go = 1'b0; exp_win = 1'b0;
    if (with_lits) begin
      lit("rst_mid_colour", F_COL, 0);
      lit("rst_mid_score",  F_SC,  0);
      lit("rst_mid_busy",   F_BUSY, 0);
      lit("rst_mid_go",     F_GO,  0);
      lit("rst_mid_win",    F_WIN, 0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en  = 1'b1;
    reset_n = 1'b1;
    lit("reset_colour", F_COL, 0);
    lit("reset_score",  F_SC,  0);
    lit("reset_busy",   F_BUSY, 0);
    lit("reset_go",     F_GO,  0);
    lit("reset_win",    F_WIN, 0);

    dc(1'b0, 2'd0, 4'b1010, 1'b1);
    lit("lamp_test", F_COL, 4'b1010);

    // First round with colour 2, then replay of round two
    dc(1'b1, 2'd2, 4'b0000, 1'b1);
    lit("add_busy", F_BUSY, 1);
    dc(1'b1, 2'd2, 4'b0000, 1'b1);
    lit("show_on_1", F_COL, 4'b0100);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("show_on_2", F_COL, 4'b0100);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("show_off", F_COL, 0);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("wait_busy", F_BUSY, 1);
    dc(1'b1, 2'd0, 4'b0100, 1'b1);
    lit("press_echo", F_COL, 4'b0100);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("score_1", F_SC, 1);
    dc(1'b1, 2'd1, 4'b0000, 1'b1);
    lit("replay_first", F_COL, 4'b0100);

    // Wrong colour in round two
    run_until(P_WAIT, 20);
    dc(1'b1, 2'd0, 4'b0001, 1'b1);
    lit("wrong_go",     F_GO,  1);
    lit("wrong_colour", F_COL, 4'b1111);
    lit("wrong_score",  F_SC,  1);
    dc(1'b0, 2'd0, 4'b0000, 1'b1);
    lit("idle_go",   F_GO,  0);
    lit("idle_busy", F_BUSY, 0);

    // Timeout, then a press on the final tick
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    run_until(P_WAIT, 20);
    repeat (7) dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("before_timeout_go", F_GO, 0);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("timeout_go", F_GO, 1);
    dc(1'b0, 2'd0, 4'b0000, 1'b1);
    dc(1'b1, 2'd3, 4'b0000, 1'b1);
    dc(1'b1, 2'd3, 4'b0000, 1'b1);
    run_until(P_WAIT, 20);
    repeat (7) dc(1'b1, 2'd0, 4'b0000, 1'b1);
    dc(1'b1, 2'd0, 4'b1000, 1'b1);
    lit("late_press_go",   F_GO,  0);
    lit("late_press_busy", F_BUSY, 1);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("late_score", F_SC, 1);

    // Complete the game
    play_round();
    play_round();
    lit("win_flag",   F_WIN, 1);
    lit("win_score",  F_SC,  3);
    lit("win_busy",   F_BUSY, 0);
    lit("win_colour", F_COL, 0);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("win_hold", F_WIN, 1);
    dc(1'b0, 2'd0, 4'b0000, 1'b1);
    lit("win_to_idle", F_WIN, 0);

    // Multi-button press loses
    dc(1'b1, 2'd1, 4'b0000, 1'b1);
    dc(1'b1, 2'd1, 4'b0000, 1'b1);
    run_until(P_WAIT, 20);
    dc(1'b1, 2'd0, 4'b0110, 1'b1);
    lit("multi_go", F_GO, 1);
    dc(1'b0, 2'd0, 4'b0000, 1'b1);

    // Button held from SHOW_OFF into WAIT_IN arms no press event
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    run_until(P_OFF, 20);
    dc(1'b1, 2'd0, 4'b0010, 1'b1);
    repeat (3) dc(1'b1, 2'd0, 4'b0010, 1'b1);
    lit("held_go",     F_GO,  0);
    lit("held_busy",   F_BUSY, 1);
    lit("held_colour", F_COL, 4'b0010);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    dc(1'b1, 2'd0, 4'b0001, 1'b1);
    lit("after_held_go", F_GO, 0);
    dc(1'b1, 2'd0, 4'b0000, 1'b1);
    lit("after_held_score", F_SC, 1);

    // Asynchronous reset during playback
    run_until(P_ON, 5);
    pulse_reset(1'b1);

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      logic       s;
      logic       t;
      logic [3:0] b;
      int         x;
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset(1'b0);
        continue;
      end
      t = ($urandom_range(0, 3) != 0);
      s = start;
      b = 4'b0000;
      x = $urandom_range(0, 99);
      case (m_ph)
        P_IDLE:              begin s = (x < 15); b = (x > 80) ? 4'($urandom) : 4'b0000; end
        P_ADD, P_ON, P_OFF:  begin s = 1'($urandom); b = (x < 8) ? 4'($urandom) : 4'b0000; end
        P_WAIT:              begin
                               if (x < 30)      b = oh(m_seq[m_pos]);
                               else if (x < 34) b = 4'($urandom);
                               else             b = 4'b0000;
                             end
        P_REL:               b = (x < 40) ? 4'b0000 : button;
        default:             s = (x < 30) ? 1'b0 : 1'b1;
      endcase
      dc(s, 2'($urandom), b, t);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
